// File: rtl/draw_sequencer_pkg.sv
// draw_sequencer_pkg
//   Shared definitions for the draw sequencer slice:
//   - FSM state encodings
//   - canonical drawer channel indices
//   - default screen geometry
//   - lowest-set-bit priority encoder used to pick the next channel
package draw_sequencer_pkg;

  // Upper bound on channel count handled by the priority encoder.
  localparam int MAX_CH = 32;

  // Sequencer FSM states
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SELECT  = 3'd1;
  localparam logic [2:0] S_RESTART = 3'd2;
  localparam logic [2:0] S_DRAW    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  // Channel assignment used by the game; lower index means drawn earlier.
  localparam int CH_SCREEN = 0;
  localparam int CH_LEVEL  = 1;
  localparam int CH_PADDLE = 2;
  localparam int CH_BALL   = 3;
  localparam int CH_SCORE  = 4;
  localparam int CH_LIFE   = 5;

  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;

  // Index of the lowest set bit; 0 when v is zero (caller checks for empty).
  // Scanning from the top down lets the last hit win, which is the lowest bit.
  function automatic logic [4:0] lowest_set(input logic [MAX_CH-1:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/draw_sequencer_if.sv
// draw_sequencer_if
//   Bundle of per-channel drawer signals between the sequencer and its
//   drawer sub-blocks. All per-channel buses are packed with channel i at
//   [i*W +: W].
//   master: sequencer side (drives ch_enable / ch_reset)
//   slave : drawer side (drives end/pixel/origin signals)
interface draw_sequencer_if #(
  parameter int NUM_CH = 8,
  parameter int XW     = 8,
  parameter int COLW   = 24
);
  logic [NUM_CH-1:0]      ch_enable;
  logic [NUM_CH-1:0]      ch_reset;
  logic [NUM_CH-1:0]      ch_end;
  logic [NUM_CH-1:0]      ch_we;
  logic [NUM_CH*XW-1:0]   ch_x;
  logic [NUM_CH*XW-1:0]   ch_y;
  logic [NUM_CH*COLW-1:0] ch_colour;
  logic [NUM_CH*XW-1:0]   origin_x;
  logic [NUM_CH*XW-1:0]   origin_y;

  modport master (
    output ch_enable, ch_reset,
    input  ch_end, ch_we, ch_x, ch_y, ch_colour, origin_x, origin_y
  );

  modport slave (
    input  ch_enable, ch_reset,
    output ch_end, ch_we, ch_x, ch_y, ch_colour, origin_x, origin_y
  );
endinterface

// File: rtl/draw_pixel_mux.sv
// draw_pixel_mux
//   Combinational selection of the active drawer's pixel, translation by
//   that channel's screen origin and clip test against the visible area.
//   Ports:
//     sel                      active channel index
//     ch_we/ch_x/ch_y/ch_colour packed drawer pixel buses
//     origin_x/origin_y        packed per-channel origins
//     we                       selected channel's pixel valid
//     sx/sy                    translated screen coordinates (low XW bits)
//     colour                   selected colour
//     in_screen                translated pixel lies inside the screen
module draw_pixel_mux #(
  parameter int NUM_CH   = 8,
  parameter int XW       = 8,
  parameter int COLW     = 24,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int CW       = 3
) (
  input  logic [CW-1:0]          sel,
  input  logic [NUM_CH-1:0]      ch_we,
  input  logic [NUM_CH*XW-1:0]   ch_x,
  input  logic [NUM_CH*XW-1:0]   ch_y,
  input  logic [NUM_CH*COLW-1:0] ch_colour,
  input  logic [NUM_CH*XW-1:0]   origin_x,
  input  logic [NUM_CH*XW-1:0]   origin_y,
  output logic                   we,
  output logic [XW-1:0]          sx,
  output logic [XW-1:0]          sy,
  output logic [COLW-1:0]        colour,
  output logic                   in_screen
);

  // One extra bit so an origin push past the coordinate range is clipped
  // instead of wrapping back onto the screen.
  logic [XW:0] sx_w;
  logic [XW:0] sy_w;

  always_comb begin
    we        = ch_we[sel];
    sx_w      = {1'b0, ch_x[int'(sel)*XW +: XW]} + {1'b0, origin_x[int'(sel)*XW +: XW]};
    sy_w      = {1'b0, ch_y[int'(sel)*XW +: XW]} + {1'b0, origin_y[int'(sel)*XW +: XW]};
    colour    = ch_colour[int'(sel)*COLW +: COLW];
    in_screen = (sx_w < (XW+1)'(SCREEN_W)) && (sy_w < (XW+1)'(SCREEN_H));
    sx        = sx_w[XW-1:0];
    sy        = sy_w[XW-1:0];
  end

endmodule

// File: rtl/draw_sequencer.sv
// draw_sequencer
//   Once per frame, restarts and enables each pending drawer channel in
//   priority order (channel 0 first) and forwards the active drawer's
//   clipped, origin-translated pixels onto the single VGA write port.
//   Ports:
//     clk, reset       clock, asynchronous active-low reset
//     frame_tick       starts a pass (when idle and run=1)
//     run              0 = pause; no new pass, no further channels
//     mode             0 = all channels, 1 = only channels with dirty set
//     dirty            per-channel redraw request, sampled at pass start
//     dif (master)     drawer handshake and pixel buses
//     x/y/colour       registered screen pixel, held between writes
//     writeEn          registered pixel write strobe
//     busy             pass in progress
//     frame_done       one-cycle pulse at end of pass
//     overrun          sticky: frame_tick while busy
//     timeout_err      sticky per-channel watchdog expiry
module draw_sequencer
  import draw_sequencer_pkg::*;
#(
  parameter int NUM_CH   = 8,
  parameter int XW       = 8,
  parameter int COLW     = 24,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int TIMEOUT  = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic              run,
  input  logic              mode,
  input  logic [NUM_CH-1:0] dirty,
  draw_sequencer_if.master  dif,
  output logic [XW-1:0]     x,
  output logic [XW-1:0]     y,
  output logic [COLW-1:0]   colour,
  output logic              writeEn,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun,
  output logic [NUM_CH-1:0] timeout_err
);

  localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WDW = $clog2(TIMEOUT + 1);

  logic [2:0]        state_q, state_d;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [CW-1:0]     cur_q, cur_d;
  logic [WDW-1:0]    wdog_q, wdog_d;
  logic [NUM_CH-1:0] ch_enable_q, ch_enable_d;
  logic [NUM_CH-1:0] ch_reset_q, ch_reset_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              overrun_q, overrun_d;
  logic [NUM_CH-1:0] timeout_err_q, timeout_err_d;
  logic [XW-1:0]     x_q, x_d, y_q, y_d;
  logic [COLW-1:0]   colour_q, colour_d;
  logic              we_q, we_d;

  logic              mux_we;
  logic [XW-1:0]     mux_sx, mux_sy;
  logic [COLW-1:0]   mux_colour;
  logic              mux_in_screen;

  draw_pixel_mux #(
    .NUM_CH  (NUM_CH),
    .XW      (XW),
    .COLW    (COLW),
    .SCREEN_W(SCREEN_W),
    .SCREEN_H(SCREEN_H),
    .CW      (CW)
  ) u_mux (
    .sel      (cur_q),
    .ch_we    (dif.ch_we),
    .ch_x     (dif.ch_x),
    .ch_y     (dif.ch_y),
    .ch_colour(dif.ch_colour),
    .origin_x (dif.origin_x),
    .origin_y (dif.origin_y),
    .we       (mux_we),
    .sx       (mux_sx),
    .sy       (mux_sy),
    .colour   (mux_colour),
    .in_screen(mux_in_screen)
  );

  // Sequencer FSM
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    cur_d         = cur_q;
    wdog_d        = wdog_q;
    timeout_err_d = timeout_err_q;
    overrun_d     = overrun_q | (frame_tick & busy_q);

    case (state_q)
      S_IDLE: begin
        if (frame_tick && run) begin
          pending_d = mode ? dirty : '1;
          state_d   = S_SELECT;
        end
      end
      S_SELECT: begin
        // A pause lands here: the channel in flight has already finished,
        // so the rest of the pass is simply dropped.
        if (!run || pending_q == '0) begin
          pending_d = '0;
          state_d   = S_DONE;
        end else begin
          cur_d   = CW'(lowest_set(MAX_CH'(pending_q)));
          state_d = S_RESTART;
        end
      end
      S_RESTART: begin
        wdog_d  = '0;
        state_d = S_DRAW;
      end
      S_DRAW: begin
        wdog_d = wdog_q + 1'b1;
        // End wins over an expiry in the same cycle.
        if (dif.ch_end[cur_q]) begin
          pending_d[cur_q] = 1'b0;
          state_d          = S_SELECT;
        end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
          timeout_err_d[cur_q] = 1'b1;
          pending_d[cur_q]     = 1'b0;
          state_d              = S_SELECT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Handshake outputs are registered decodes of the next state.
    ch_enable_d  = (state_d == S_DRAW)    ? (NUM_CH'(1) << cur_d) : '0;
    ch_reset_d   = (state_d == S_RESTART) ? (NUM_CH'(1) << cur_d) : '0;
    busy_d       = (state_d == S_SELECT) || (state_d == S_RESTART) || (state_d == S_DRAW);
    frame_done_d = (state_d == S_DONE);
  end

  // Pixel write port: one cycle behind the drawer, holds between writes.
  always_comb begin
    we_d     = mux_we && (state_q == S_DRAW) && mux_in_screen;
    x_d      = we_d ? mux_sx     : x_q;
    y_d      = we_d ? mux_sy     : y_q;
    colour_d = we_d ? mux_colour : colour_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      pending_q     <= '0;
      cur_q         <= '0;
      wdog_q        <= '0;
      ch_enable_q   <= '0;
      ch_reset_q    <= '0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= '0;
      x_q           <= '0;
      y_q           <= '0;
      colour_q      <= '0;
      we_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      cur_q         <= cur_d;
      wdog_q        <= wdog_d;
      ch_enable_q   <= ch_enable_d;
      ch_reset_q    <= ch_reset_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
      x_q           <= x_d;
      y_q           <= y_d;
      colour_q      <= colour_d;
      we_q          <= we_d;
    end
  end

  assign dif.ch_enable = ch_enable_q;
  assign dif.ch_reset  = ch_reset_q;
  assign x             = x_q;
  assign y             = y_q;
  assign colour        = colour_q;
  assign writeEn       = we_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign overrun       = overrun_q;
  assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_draw_sequencer.sv
// tb_draw_sequencer
//   Four-channel bench with reactive drawer models. Expected restart order
//   and expected pixels are queued as stimulus is set up / driven, and
//   popped when the DUT pulses ch_reset or writeEn.
module tb_draw_sequencer;
  import draw_sequencer_pkg::*;

  localparam int NCH  = 4;
  localparam int XW   = 8;
  localparam int COLW = 24;
  localparam int TO   = 20;

  logic            clk = 1'b0;
  logic            reset;
  logic            frame_tick, run, mode;
  logic [NCH-1:0]  dirty;
  logic [XW-1:0]   x, y;
  logic [COLW-1:0] colour;
  logic            writeEn, busy, frame_done, overrun;
  logic [NCH-1:0]  timeout_err;

  draw_sequencer_if #(.NUM_CH(NCH), .XW(XW), .COLW(COLW)) dif ();

  draw_sequencer #(
    .NUM_CH(NCH), .XW(XW), .COLW(COLW),
    .SCREEN_W(160), .SCREEN_H(120), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .run(run), .mode(mode),
    .dirty(dirty), .dif(dif), .x(x), .y(y), .colour(colour), .writeEn(writeEn),
    .busy(busy), .frame_done(frame_done), .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc <= cyc + 1;
  end

  // scoreboards and observation state
  int            rst_q[$];
  logic [39:0]   pix_q[$];
  logic          trk_rst = 1'b0;
  logic [NCH-1:0] en_seen = '0;
  int            en1_cyc = 0;
  int            n_done = 0, done_cyc = 0, n_we = 0;
  int            first_rst_cyc = -1;
  // drawer behaviour knobs
  logic [NCH-1:0] hang = '0, pix = '0, noise = '0;
  int            cnt[NCH];
  int            org_x2 = 0;

  // Monitors + drawer models, evaluated on the falling edge.
  initial begin
    dif.ch_end = '0; dif.ch_we = '0; dif.ch_x = '0; dif.ch_y = '0; dif.ch_colour = '0;
    for (int i = 0; i < NCH; i++) cnt[i] = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        for (int i = 0; i < NCH; i++) cnt[i] = 0;
        dif.ch_end = '0;
        dif.ch_we  = '0;
      end else begin
        chk("enable_onehot", 64'($countones(dif.ch_enable) <= 1), 1);
        en_seen |= dif.ch_enable;
        if (dif.ch_enable[1]) en1_cyc++;
        if (dif.ch_reset != '0) begin
          if (first_rst_cyc < 0) first_rst_cyc = cyc;
          if (trk_rst) begin
            if (rst_q.size() == 0) chk("rst_extra", 64'(dif.ch_reset), 0);
            else chk("rst_order", 64'(dif.ch_reset), 64'(1) << rst_q.pop_front());
          end
        end
        if (frame_done) begin
          n_done++;
          done_cyc = cyc;
        end
        if (writeEn) begin
          n_we++;
          if (pix_q.size() == 0) chk("pix_extra", {writeEn, x, y, colour}, 0);
          else chk("pix", {x, y, colour}, 64'(pix_q.pop_front()));
        end
        for (int i = 0; i < NCH; i++) begin
          if (dif.ch_reset[i]) cnt[i] = 0;
          if (dif.ch_enable[i]) begin
            cnt[i]++;
            if (pix[i]) begin
              if (cnt[i] <= 16) begin
                dif.ch_we[i] = 1'b1;
                dif.ch_x[i*XW +: XW] = 8'(cnt[i] - 1);
                dif.ch_y[i*XW +: XW] = 8'd5;
                dif.ch_colour[i*COLW +: COLW] = {16'h2200, 8'(cnt[i])};
                if ((cnt[i] - 1) + org_x2 < 160)
                  pix_q.push_back({8'((cnt[i] - 1) + org_x2), 8'd5, 16'h2200, 8'(cnt[i])});
              end else begin
                dif.ch_we[i]  = 1'b0;
                dif.ch_end[i] = 1'b1;
              end
            end else begin
              dif.ch_we[i]  = 1'b0;
              dif.ch_end[i] = !hang[i] && cnt[i] >= 10;
            end
          end else begin
            dif.ch_end[i] = 1'b0;
            // an idle noisy drawer pushes on-screen pixels that must be ignored
            dif.ch_we[i]  = noise[i];
            if (noise[i]) begin
              dif.ch_x[i*XW +: XW] = 8'd3;
              dif.ch_y[i*XW +: XW] = 8'd3;
            end
          end
        end
      end
    end
  end

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Pulse frame_tick for one cycle; tick_cyc is the cycle count at drive time.
  int tick_cyc;
  task automatic pulse_tick();
    tick_cyc   = cyc;
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int k;
    k = 0;
    while (n_done == d0 && k < 400) begin
      step(1);
      k++;
    end
    if (n_done == d0) chk("wait_done_expired", 0, 1);
  endtask

  task automatic wait_en(input int ch);
    int k;
    k = 0;
    while (!dif.ch_enable[ch] && k < 200) begin
      step(1);
      k++;
    end
    if (!dif.ch_enable[ch]) chk("wait_en_expired", 64'(ch), 64'hff);
  endtask

  int d0;

  initial begin
    reset = 1'b0; frame_tick = 1'b0; run = 1'b0; mode = 1'b0; dirty = '0;
    dif.origin_x = '0; dif.origin_y = '0;
    step(3);
    chk("reset_outs", {x, y, colour, writeEn, busy, frame_done, overrun, timeout_err,
                       dif.ch_enable, dif.ch_reset}, 0);
    reset = 1'b1;
    step(2);

    // reset asserted in the middle of channel 0's draw
    run = 1'b1; mode = 1'b0;
    pulse_tick();
    wait_en(0);
    step(3);
    reset = 1'b0;
    #1;
    chk("midreset_outs", {x, y, colour, writeEn, busy, frame_done, overrun, timeout_err,
                          dif.ch_enable, dif.ch_reset}, 0);
    step(2);
    chk("midreset_no_pulse", 64'(dif.ch_reset), 0);
    reset = 1'b1;
    step(2);

    // mode 0 full pass, restart latency and channel order
    trk_rst = 1'b1;
    for (int i = 0; i < NCH; i++) rst_q.push_back(i);
    en_seen = '0; first_rst_cyc = -1; d0 = n_done;
    pulse_tick();
    wait_done(d0);
    step(3);
    chk("m0_rst_latency", 64'(first_rst_cyc - tick_cyc), 2);
    chk("m0_done_once", 64'(n_done - d0), 1);
    chk("m0_busy_after", 64'(busy), 0);
    chk("m0_en_seen", 64'(en_seen), 4'hf);
    chk("m0_rst_left", 64'(rst_q.size()), 0);

    // mode 1, dirty = 1010
    mode = 1'b1; dirty = 4'b1010;
    rst_q.push_back(1); rst_q.push_back(3);
    en_seen = '0; d0 = n_done;
    pulse_tick();
    wait_done(d0);
    step(3);
    chk("m1_en_seen", 64'(en_seen), 4'b1010);
    chk("m1_rst_left", 64'(rst_q.size()), 0);

    // mode 1, nothing dirty
    dirty = '0; en_seen = '0; d0 = n_done;
    pulse_tick();
    wait_done(d0);
    step(3);
    chk("m1_empty_latency", 64'(done_cyc - tick_cyc), 2);
    chk("m1_empty_en", 64'(en_seen), 0);
    chk("m1_empty_busy", 64'(busy), 0);

    // pixel path: channel 2 at origin_x 150, x clipped at 160
    dirty = 4'b0100; org_x2 = 150; dif.origin_x[2*XW +: XW] = 8'd150;
    pix = 4'b0100; noise = 4'b1000; n_we = 0;
    rst_q.push_back(2);
    d0 = n_done;
    pulse_tick();
    wait_done(d0);
    step(3);
    chk("pix_count", 64'(n_we), 10);
    chk("pix_left", 64'(pix_q.size()), 0);
    chk("pix_hold_x", 64'(x), 159);
    pix = '0; noise = '0; org_x2 = 0; dif.origin_x = '0;

    // watchdog: channel 1 hangs; overrun from a tick mid-pass
    mode = 1'b0; hang = 4'b0010;
    for (int i = 0; i < NCH; i++) rst_q.push_back(i);
    en_seen = '0; en1_cyc = 0; d0 = n_done;
    pulse_tick();
    wait_en(1);
    chk("pre_overrun", 64'(overrun), 0);
    pulse_tick();
    wait_done(d0);
    step(3);
    chk("to_en_cycles", 64'(en1_cyc), TO);
    chk("to_err", 64'(timeout_err), 4'b0010);
    chk("to_overrun", 64'(overrun), 1);
    chk("to_en_seen", 64'(en_seen), 4'hf);
    chk("to_rst_left", 64'(rst_q.size()), 0);
    chk("to_done_once", 64'(n_done - d0), 1);
    hang = '0;

    // pause while channel 0 draws
    rst_q.push_back(0);
    en_seen = '0; d0 = n_done;
    pulse_tick();
    wait_en(0);
    run = 1'b0;
    wait_done(d0);
    step(3);
    chk("pause_en_seen", 64'(en_seen), 4'b0001);
    chk("pause_rst_left", 64'(rst_q.size()), 0);
    chk("pause_busy", 64'(busy), 0);
    chk("sticky_err", 64'(timeout_err), 4'b0010);

    // tick with run low is ignored
    d0 = n_done;
    pulse_tick();
    step(5);
    chk("paused_tick_busy", 64'(busy), 0);
    chk("paused_tick_done", 64'(n_done - d0), 0);
    chk("pix_final_left", 64'(pix_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/draw_sequencer.md
Name: draw_sequencer

Overview:
- Parametrised successor to the hand-wired enable/end/reset draw handshakes between game control and datapath.
- Sequences NUM_CH drawer sub-blocks (screen, level, paddle, ball, score, lives, ...) once per frame and muxes the active drawer's pixel stream onto the single VGA write port.
- Adds a per-channel screen origin, clips to the screen and supports a dirty-only redraw mode.
- Adds a per-channel watchdog and overrun detection.

Parameters:
NUM_CH, 8, number of drawer channels; channel 0 has the highest priority and is drawn first.
XW, 8, pixel coordinate width for x and y.
COLW, 24, colour width.
SCREEN_W, 160, visible width; x >= SCREEN_W is clipped.
SCREEN_H, 120, visible height; y >= SCREEN_H is clipped.
TIMEOUT, 65535, maximum cycles a channel may stay enabled before it is abandoned.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-low
frame_tick  in  1  one-cycle pulse; starts a frame pass
run  in  1  1 = game running; 0 = pause, with no new frame started
mode  in  1  0 = draw all channels; 1 = draw only channels whose dirty bit is set
dirty  in  NUM_CH  per-channel redraw request, sampled at frame start
ch_enable  out  NUM_CH  one-hot enable to the active drawer
ch_reset  out  NUM_CH  one-cycle active-high restart pulse to a drawer
ch_end  in  NUM_CH  drawer finished, level-sensitive
ch_we  in  NUM_CH  drawer pixel valid
ch_x  in  NUM_CH*XW  drawer-local x, packed with channel i at [i*XW +: XW]
ch_y  in  NUM_CH*XW  drawer-local y, packed
ch_colour  in  NUM_CH*COLW  drawer colour, packed
origin_x  in  NUM_CH*XW  per-channel screen origin x
origin_y  in  NUM_CH*XW  per-channel screen origin y
x  out  XW  screen x
y  out  XW  screen y
colour  out  COLW  pixel colour
writeEn  out  1  pixel write strobe
busy  out  1  frame pass in progress
frame_done  out  1  one-cycle pulse when a pass completes
overrun  out  1  sticky; a frame_tick arrived while busy
timeout_err  out  NUM_CH  sticky per-channel watchdog flag

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. All outputs are 0: x, y, colour, writeEn, ch_enable, ch_reset, busy, frame_done, overrun, timeout_err. Internal pending mask and watchdog counter are 0.
- FSM states: IDLE, SELECT, RESTART, DRAW, DONE.
- IDLE -> SELECT when frame_tick=1 and run=1.
  - pending is latched: all-ones in mode 0; dirty in mode 1.
  - busy rises the next cycle.
  - frame_tick with run=0 is ignored.
- SELECT:
  - Picks the lowest set bit of pending as cur.
  - If pending=0, goes to DONE. A mode 1 frame with dirty=0 reaches DONE 2 cycles after the tick.
- RESTART:
  - ch_reset[cur]=1 for exactly one cycle.
  - Watchdog is cleared.
  - Then DRAW.
- DRAW:
  - ch_enable[cur]=1 and the watchdog increments each cycle.
  - When ch_end[cur]=1: clear pending[cur], drop enable the same cycle (registered, so low the next cycle), go to SELECT.
  - If the watchdog reaches TIMEOUT: set timeout_err[cur], clear pending[cur], go to SELECT.
  - ch_end and timeout in the same cycle: treated as normal end, with no error.
- DONE: frame_done=1 for one cycle, busy=0, then IDLE.
- Pixel path:
  - Registered, with 1-cycle latency from ch_we[cur].
  - Sums are computed at XW+1 bits: sx = ch_x[cur]+origin_x[cur], sy likewise.
  - writeEn = ch_we[cur] & in DRAW & sx<SCREEN_W & sy<SCREEN_H.
  - x/y/colour update only when writeEn is asserted and otherwise hold.
  - ch_we from non-active channels is ignored.
- run=0 mid-pass: the current channel completes, no further channels are selected, pending is discarded, and the FSM goes to DONE. The pause takes effect at the next SELECT.
- frame_tick while busy: ignored and overrun set. overrun and timeout_err clear only on reset.
- reset asserted mid-pass: immediate return to the reset state. No ch_reset pulse is emitted.

Decomposition:
- Shared package: state enum; channel index constants (CH_SCREEN=0, CH_LEVEL=1, CH_PADDLE=2, CH_BALL=3, CH_SCORE=4, CH_LIFE=5); default SCREEN_W/SCREEN_H.
- One sub-module, draw_pixel_mux: combinational index-select of the packed buses plus origin add and clip, with the output register in the parent. Priority-encoder function in the package.

Test Plan:
- Reset with reset=0 mid-DRAW -> all outputs 0 within the same cycle, no ch_reset. Then release, tick -> ch_reset[0] pulse 2 cycles after the tick.
- Mode 0, NUM_CH=4, each drawer asserts ch_end after 10 cycles.
  - ch_reset pulses on channels 0,1,2,3 in order.
  - ch_enable is never multi-hot.
  - frame_done pulses once, and busy is low afterwards.
- Mode 1, dirty=4'b1010 -> only channels 1 and 3 are restarted/enabled. dirty=0 -> frame_done 2 cycles after the tick, no enable.
- Channel 2 origin_x=150, ch_x 0..15 with ch_we=1 -> writeEn high for ch_x 0..9 only; x=150..159 one cycle after each ch_we.
- TIMEOUT=20, channel 1 never ends -> enable dropped after 20 cycles, timeout_err=4'b0010, channel 2 proceeds. frame_tick during the pass -> overrun=1.
- run drops while channel 0 is drawing -> channel 0 finishes, channel 1 is never enabled, frame_done pulses.
